// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, encodings and alignment helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int TMO_W = 8;

    // True when the access cannot be issued: illegal size or an address not aligned to the size
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SIZE_B:  bad_access = 1'b0;
            SIZE_H:  bad_access = a[0];
            SIZE_W:  bad_access = (a != 2'b00);
            default: bad_access = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/store-lane generation and load-lane extract with sign/zero extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_bad_o,
    input  logic [1:0]  rsp_addr_i,
    input  logic [1:0]  rsp_size_i,
    input  logic        rsp_unsigned_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    // Request side: lanes the access touches and the store data replicated onto every lane
    always_comb begin
        req_be_o    = 4'b1111;
        req_wdata_o = req_wdata_i;
        case (req_size_i)
            SIZE_B: begin
                req_be_o    = 4'b0001 << req_addr_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            SIZE_H: begin
                req_be_o    = 4'b0011 << {req_addr_i[1], 1'b0};
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_be_o    = 4'b1111;
                req_wdata_o = req_wdata_i;
            end
        endcase
        req_bad_o = bad_access(req_size_i, req_addr_i);
    end

    // Response side: pull the addressed lane down to bit 0 and extend to 32 bits
    always_comb begin
        rsp_byte   = rsp_rdata_i[{rsp_addr_i, 3'b000} +: 8];
        rsp_half   = rsp_rdata_i[{rsp_addr_i[1], 4'b0000} +: 16];
        rsp_data_o = rsp_rdata_i;
        case (rsp_size_i)
            SIZE_B:  rsp_data_o = rsp_unsigned_i ? {24'd0, rsp_byte} : {{24{rsp_byte[7]}}, rsp_byte};
            SIZE_H:  rsp_data_o = rsp_unsigned_i ? {16'd0, rsp_half} : {{16{rsp_half[15]}}, rsp_half};
            default: rsp_data_o = rsp_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: accepts execute ops, runs req/gnt/rvalid bus, returns write-back beats
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_wdata,
    output logic        lsu_ready,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q;
    logic [TMO_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             wb_valid_q;
    logic [31:0]      wb_data_q;
    logic             lsu_err_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic [31:0]      bus_addr_q;
    logic [3:0]       bus_be_q;
    logic [31:0]      bus_wdata_q;

    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic             req_bad;
    logic [31:0]      load_data;
    logic             timed_out;

    lsu_align u_align (
        .req_addr_i     (ex_result[1:0]),
        .req_size_i     (ex_size),
        .req_wdata_i    (ex_wdata),
        .req_be_o       (req_be),
        .req_wdata_o    (req_wdata),
        .req_bad_o      (req_bad),
        .rsp_addr_i     (addr_lo_q),
        .rsp_size_i     (size_q),
        .rsp_unsigned_i (uns_q),
        .rsp_rdata_i    (bus_rdata),
        .rsp_data_o     (load_data)
    );

    assign timed_out = (cnt_q == TMO_LAST);

    // FSM, timeout counter and all registered outputs; wb_valid/lsu_err are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            lsu_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            lsu_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!ex_mem_rd && !ex_mem_wr) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ex_result;
                        end else if (req_bad || (ex_mem_rd && ex_mem_wr)) begin
                            lsu_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_REQ;
                            cnt_q       <= '0;
                            addr_lo_q   <= ex_result[1:0];
                            size_q      <= ex_size;
                            uns_q       <= ex_unsigned;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= ex_mem_wr;
                            bus_addr_q  <= {ex_result[31:2], 2'b00};
                            bus_be_q    <= req_be;
                            bus_wdata_q <= req_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant in the last allowed cycle still completes the op
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (bus_we_q) begin
                            state_q    <= ST_IDLE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (timed_out) begin
                        state_q   <= ST_IDLE;
                        bus_req_q <= 1'b0;
                        lsu_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_data;
                    end else if (timed_out) begin
                        state_q   <= ST_IDLE;
                        lsu_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lsu_ready = (state_q == ST_IDLE);
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign lsu_err   = lsu_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: vector table, scoreboard, multi-cycle corner sequences
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic        ex_unsigned = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_wdata = '0;
    logic        lsu_ready;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        logic [31:0] rdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];

    lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_result(ex_result), .ex_wdata(ex_wdata),
        .lsu_ready(lsu_ready), .wb_valid(wb_valid), .wb_data(wb_data), .lsu_err(lsu_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every wb_valid / lsu_err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (wb_valid || lsu_err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: wb_valid=%0b lsu_err=%0b wb_data=0x%08h, expected none",
                         wb_valid, lsu_err, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_err", {31'd0, lsu_err}, {31'd0, e.err});
                chk("resp_wb_valid", {31'd0, wb_valid}, {31'd0, !e.err});
                if (!e.err) chk("resp_wb_data", wb_data, e.data);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 16 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
        ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr; ex_size = size;
        ex_unsigned = uns; ex_result = addr; ex_wdata = wd;
    endtask

    task automatic push_exp(input logic err, input logic [31:0] data);
        exp_t e;
        e.err = err;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive_op(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata);
        push_exp(v.exp_err, v.exp_wb);
        chk($sformatf("v%0d_ready_at_accept", idx), {31'd0, lsu_ready}, 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        if (!(v.rd || v.wr) || v.exp_err) begin
            chk($sformatf("v%0d_no_bus_req", idx), {31'd0, bus_req}, 32'd0);
            chk($sformatf("v%0d_ready_stays", idx), {31'd0, lsu_ready}, 32'd1);
        end else begin
            for (int k = 0; k <= v.gnt_dly; k++) begin
                chk($sformatf("v%0d_req_k%0d", idx, k), {31'd0, bus_req}, 32'd1);
                chk($sformatf("v%0d_we_k%0d", idx, k), {31'd0, bus_we}, {31'd0, v.wr});
                chk($sformatf("v%0d_addr_k%0d", idx, k), bus_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_be_k%0d", idx, k), {28'd0, bus_be}, {28'd0, v.exp_be});
                chk($sformatf("v%0d_busy_k%0d", idx, k), {31'd0, lsu_ready}, 32'd0);
                if (v.wr) chk($sformatf("v%0d_wdata_k%0d", idx, k), bus_wdata, v.exp_bwdata);
                bus_gnt = (k == v.gnt_dly);
                if (bus_gnt && v.rd) begin
                    bus_rvalid = 1'b1;
                    bus_rdata = ~v.rdata;
                end
                @(posedge clk);
                #1;
                bus_gnt = 1'b0;
                bus_rvalid = 1'b0;
            end
            if (v.rd) begin
                chk($sformatf("v%0d_req_drop", idx), {31'd0, bus_req}, 32'd0);
                bus_rvalid = 1'b1;
                bus_rdata = v.rdata;
                @(posedge clk);
                #1;
                bus_rvalid = 1'b0;
            end
        end
        drain();
    endtask

    initial begin
        //          rd    wr    size   uns   addr           wdata          dly rdata          err   be       bwdata         wb
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0,         0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_1234};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         0, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         3, 32'h8001_0000, 1'b0, 4'b1100, 32'h0,         32'h0000_8001};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00AB, 0, 32'h0,         1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         1, 32'h1234_8765, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8765};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 2, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1111_CAFE, 0, 32'h0,         1'b0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,         0, 32'h0000_9A00, 1'b0, 4'b0010, 32'h0,         32'h0000_009A};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         0, 32'h89AB_CDEF, 1'b0, 4'b1111, 32'h0,         32'h89AB_CDEF};
        vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0,         0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err", {31'd0, lsu_err}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Back-to-back ALU ops: one write-back per cycle
        drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'hA5A5_0001, 32'h0);
        push_exp(1'b0, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h5A5A_0002, 32'h0);
        push_exp(1'b0, 32'h5A5A_0002);
        chk("b2b_ready", {31'd0, lsu_ready}, 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        drain();

        // Timeout in REQ: no grant for 4 cycles
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        push_exp(1'b1, 32'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo_req_k%0d", k), {31'd0, bus_req}, 32'd1);
            @(posedge clk);
            #1;
        end
        chk("tmo_req_dropped", {31'd0, bus_req}, 32'd0);
        chk("tmo_ready_back", {31'd0, lsu_ready}, 32'd1);
        drain();

        // Timeout in WAIT, then a late rvalid that must be ignored
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0408, 32'h0);
        push_exp(1'b1, 32'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        chk("wtmo_in_wait", {31'd0, lsu_ready}, 32'd0);
        drain();
        bus_rvalid = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        chk("wtmo_late_rvalid", {31'd0, wb_valid}, 32'd0);

        // Reset while in REQ: bus_req drops on the next edge
        drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("rreq_req_up", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rreq_req_down", {31'd0, bus_req}, 32'd0);
        chk("rreq_ready", {31'd0, lsu_ready}, 32'd1);

        // Reset while in WAIT, then late rvalid produces nothing
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rwait_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rwait_wb_valid", {31'd0, wb_valid}, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        chk("rwait_late_rvalid", {31'd0, wb_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
